// File: rtl/imap_biu_pk_if.sv
// Arbiter-side read bus of the input-feature-map BIU: request channel out, response channel in.
interface imap_biu_pk_if #(
  parameter int unsigned BUS_W = 32
);
  logic             imap_biu2arb_req;
  logic [31:0]      imap_biu2arb_addr;
  logic             imap_biu2arb_vld;
  logic             imap_biu2arb_rdy;
  logic [BUS_W-1:0] arb2imap_biu_data;
  logic             arb2imap_biu_vld;
  logic             arb2imap_biu_rdy;

  modport master (
    output imap_biu2arb_req, imap_biu2arb_addr, imap_biu2arb_vld, arb2imap_biu_rdy,
    input  imap_biu2arb_rdy, arb2imap_biu_data, arb2imap_biu_vld
  );

  modport slave (
    input  imap_biu2arb_req, imap_biu2arb_addr, imap_biu2arb_vld, arb2imap_biu_rdy,
    output imap_biu2arb_rdy, arb2imap_biu_data, arb2imap_biu_vld
  );
endinterface

// File: rtl/imap_biu_pk.sv
// Input-feature-map BIU: bounded-outstanding burst reader that packs PACK beats per SRAM word,
// written round-robin across NBANK banks. Define IMAP_BIU_STALL_CNT_EN to add the stall_cnt port.
module imap_biu_pk #(
  parameter int unsigned BUS_W      = 32,
  parameter int unsigned PACK       = 2,
  parameter int unsigned NBANK      = 8,
  parameter int unsigned BANK_DEPTH = 3136,
  parameter int unsigned MAX_OUTST  = 8,
  parameter int unsigned CNT_W      = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    imap_start,
  input  logic [CNT_W-1:0]        xfer_len,
  input  logic [31:0]             imap_base_addr,
  output logic                    busy,
  output logic                    imap_done,
  imap_biu_pk_if.master           arb,
  output logic [31:0]             imap_waddr,
  output logic [BUS_W*PACK-1:0]   imap_wdata,
  output logic                    imap_wen
`ifdef IMAP_BIU_STALL_CNT_EN
  ,
  output logic [31:0]             stall_cnt
`endif
);

  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned BW = (PACK - 1) * BUS_W;

  typedef enum logic [1:0] {StIdle, StReq, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0] rcv_cnt_q, rcv_cnt_d;
  logic [OW-1:0]    outst_q, outst_d;
  logic [31:0]      addr_q, addr_d;
  logic [BW-1:0]    pack_q, pack_d;
  logic             req_q, req_d;
  logic             done_q, done_d;

  logic             start_ok, req_hs, beat, pack_last;
  logic [BW+BUS_W-1:0] wdata_raw;
  logic [CNT_W-1:0] word_idx, bank_idx, row_idx;

  assign start_ok  = imap_start && (state_q == StIdle);
  assign arb.imap_biu2arb_vld = (state_q == StReq) && (outst_q < OW'(MAX_OUTST));
  assign req_hs    = arb.imap_biu2arb_vld && arb.imap_biu2arb_rdy;
  // Beats outside an active transfer are stale responses and are discarded.
  assign beat      = arb.arb2imap_biu_vld && ((state_q == StReq) || (state_q == StDrain));
  assign pack_last = (rcv_cnt_q % CNT_W'(PACK)) == CNT_W'(PACK - 1);

  assign wdata_raw = {pack_q, arb.arb2imap_biu_data};
  assign word_idx  = rcv_cnt_q / CNT_W'(PACK);
  assign bank_idx  = word_idx % CNT_W'(NBANK);
  assign row_idx   = word_idx / CNT_W'(NBANK);

  assign imap_wen   = beat && pack_last;
  assign imap_wdata = imap_wen ? wdata_raw : '0;
  assign imap_waddr = 32'(bank_idx) * BANK_DEPTH + 32'(row_idx);

  assign busy                  = (state_q != StIdle);
  assign imap_done             = done_q;
  assign arb.imap_biu2arb_req  = req_q;
  assign arb.imap_biu2arb_addr = addr_q;
  assign arb.arb2imap_biu_rdy  = 1'b1;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    req_cnt_d = req_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    outst_d   = outst_q;
    addr_d    = addr_q;
    pack_d    = pack_q;

    if (start_ok) begin
      len_d     = xfer_len;
      addr_d    = imap_base_addr;
      req_cnt_d = '0;
      rcv_cnt_d = '0;
      outst_d   = '0;
      pack_d    = '0;
    end else begin
      if (req_hs) begin
        addr_d    = addr_q + 32'(BUS_W / 8);
        req_cnt_d = req_cnt_q + CNT_W'(1);
      end
      if (beat) begin
        rcv_cnt_d = rcv_cnt_q + CNT_W'(1);
        if (!pack_last) pack_d = wdata_raw[BW-1:0];
      end
      if (req_hs && !beat) begin
        outst_d = outst_q + OW'(1);
      end else if (!req_hs && beat && (outst_q != '0)) begin
        outst_d = outst_q - OW'(1);
      end
    end

    unique case (state_q)
      StIdle:  if (imap_start) state_d = (xfer_len == '0) ? StDone : StReq;
      StReq:   if (req_hs && (req_cnt_q == len_q - CNT_W'(1))) state_d = StDrain;
      StDrain: if (rcv_cnt_d == len_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    req_d  = (state_d == StReq) || (state_d == StDrain);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      len_q     <= '0;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      outst_q   <= '0;
      addr_q    <= '0;
      pack_q    <= '0;
      req_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      outst_q   <= outst_d;
      addr_q    <= addr_d;
      pack_q    <= pack_d;
      req_q     <= req_d;
      done_q    <= done_d;
    end
  end

`ifdef IMAP_BIU_STALL_CNT_EN
  logic [31:0] stall_q;

  // In REQ, any cycle without a handshake is a stall (arbiter busy or window full).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (start_ok) begin
      stall_q <= '0;
    end else if ((state_q == StReq) && !req_hs && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`endif

endmodule
